// File: rtl/serial_to_par_8_pkg.sv
// Shared definitions for the serial-to-parallel receiver of the 32/8 link.
package serial_to_par_8_pkg;

  // Comma/idle symbol the transmitter sends whenever it has no data.
  localparam logic [7:0] DEFAULT_IDLE_BYTE = 8'hBC;

  // Consecutive idle bytes needed before the link counts as synchronised.
  localparam int DEFAULT_SYNC_COUNT = 4;

  // Link synchronisation state.
  typedef enum logic {
    SEARCH = 1'b0,
    ACTIVE = 1'b1
  } link_state_e;

  // Bits needed to hold a counter that reaches max_val (never less than 1).
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_to_par_8_idle_sync_fsm.sv
// Idle-run detector: watches completed bytes, declares the link active after
// SYNC_COUNT consecutive idle bytes, then flags every non-idle byte as data.
module serial_to_par_8_idle_sync_fsm
  import serial_to_par_8_pkg::*;
#(
  parameter logic [7:0] IDLE_BYTE  = DEFAULT_IDLE_BYTE,
  parameter int         SYNC_COUNT = DEFAULT_SYNC_COUNT
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       i_byte_done,
  input  logic [7:0] i_byte,
  output logic       o_active,
  output logic       o_accept
);

  localparam int                CNT_W     = cnt_width(SYNC_COUNT);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_COUNT - 1);
  localparam logic [CNT_W-1:0] SYNC_FULL = CNT_W'(SYNC_COUNT);

  link_state_e      r_state;
  link_state_e      w_state_next;
  logic [CNT_W-1:0] r_idle_cnt;
  logic [CNT_W-1:0] w_idle_cnt_next;
  logic             w_is_idle;

  assign w_is_idle = (i_byte == IDLE_BYTE);

  // State and idle-run counter registers, cleared by synchronous reset.
  always_ff @(posedge clk_32f) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    if (reset) begin
      r_state    <= SEARCH;
      r_idle_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_idle_cnt <= w_idle_cnt_next;
    end
  end

  // Next-state, idle-run counting and data-accept decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    w_state_next    = r_state;
    w_idle_cnt_next = r_idle_cnt;
    o_accept        = 1'b0;
    unique case (r_state)
      SEARCH: begin
        if (i_byte_done) begin
          if (w_is_idle) begin
            if (r_idle_cnt == SYNC_LAST) begin
              // Run complete: counter parks at its saturation value.
              w_idle_cnt_next = SYNC_FULL;
              w_state_next    = ACTIVE;
            end else begin
              w_idle_cnt_next = r_idle_cnt + 1'b1;
            end
          end else begin
            w_idle_cnt_next = '0;
          end
        end
      end
      ACTIVE: begin
        // Sticky until reset; only non-idle bytes are data.
        o_accept = i_byte_done && !w_is_idle;
      end
      default: begin
        w_state_next = SEARCH;
      end
    endcase
  end

  // Active is decoded straight from the state register, so it is glitch-free
  // and rises on the same edge that completes the idle run.
  assign o_active = (r_state == ACTIVE);

endmodule

// File: rtl/serial_to_par_8.sv
// Serial-to-parallel receiver: shifts in one bit per clk_32f edge, MSB first,
// frames bytes on fixed 8-bit boundaries from reset, and presents non-idle
// bytes once the link has synchronised on a run of idle symbols.
module serial_to_par_8
  import serial_to_par_8_pkg::*;
#(
  parameter logic [7:0] IDLE_BYTE  = DEFAULT_IDLE_BYTE,
  parameter int         SYNC_COUNT = DEFAULT_SYNC_COUNT
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic [7:0] w_byte;
  logic       w_byte_done;
  logic       w_accept;

  // The byte as it stands once this edge's bit is included.
  assign w_byte      = {r_shift[6:0], data_in};
  assign w_byte_done = (r_bit_cnt == 3'd7);

  // Bit counter, shift register and the byte-slot output registers.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'h00;
      data_out  <= 8'h00;
      valid_out <= 1'b0;
    end else begin
      r_bit_cnt <= r_bit_cnt + 3'd1;
      r_shift   <= w_byte;
      // Outputs move only at byte completion and hold for the whole slot.
      if (w_byte_done) begin
        if (w_accept) begin
          data_out  <= w_byte;
          valid_out <= 1'b1;
        end else begin
          valid_out <= 1'b0;
        end
      end
    end
  end

  serial_to_par_8_idle_sync_fsm #(
    .IDLE_BYTE  (IDLE_BYTE),
    .SYNC_COUNT (SYNC_COUNT)
  ) u_idle_sync_fsm (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .i_byte_done (w_byte_done),
    .i_byte      (w_byte),
    .o_active    (active),
    .o_accept    (w_accept)
  );

endmodule

// File: tb/tb_serial_to_par_8.sv
// Bench for serial_to_par_8: a byte-level reference model checked every cycle,
// plus hand-computed expectations at key points of each scenario.
module tb_serial_to_par_8;

  localparam logic [7:0] IDLE = 8'hBC;
  localparam int         SYNC = 4;

  logic       clk_32f;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  int n_vec;
  int n_miss;

  // Reference model state (byte-level view of the link).
  int         m_bits;
  logic [7:0] m_sr;
  int         m_idle_run;
  logic [7:0] exp_data;
  logic       exp_valid;
  logic       exp_active;
  logic       cmp_en;

  serial_to_par_8 #(
    .IDLE_BYTE  (IDLE),
    .SYNC_COUNT (SYNC)
  ) dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .active    (active)
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a byte is the last eight bits received since reset, taken every
  // eighth bit; idle runs are counted per byte until the sync threshold.
  task automatic model_edge(input logic rst, input logic b);
    logic [7:0] byte_v;
    if (rst) begin
      m_bits     = 0;
      m_sr       = 8'h00;
      m_idle_run = 0;
      exp_data   = 8'h00;
      exp_valid  = 1'b0;
      exp_active = 1'b0;
    end else begin
      m_sr   = {m_sr[6:0], b};
      m_bits = m_bits + 1;
      if (m_bits % 8 == 0) begin
        byte_v = m_sr;
        if (!exp_active) begin
          exp_valid = 1'b0;
          if (byte_v == IDLE) begin
            m_idle_run = m_idle_run + 1;
            if (m_idle_run >= SYNC) exp_active = 1'b1;
          end else begin
            m_idle_run = 0;
          end
        end else if (byte_v != IDLE) begin
          exp_data  = byte_v;
          exp_valid = 1'b1;
        end else begin
          exp_valid = 1'b0;
        end
      end
    end
  endtask

  // One clk_32f cycle: drive on the falling edge, update model after rising.
  task automatic step(input logic rst, input logic b);
    @(negedge clk_32f);
    reset   = rst;
    data_in = b;
    @(posedge clk_32f);
    #1;
    model_edge(rst, b);
    cmp_en = 1'b1;
  endtask

  task automatic send_bits(input logic [7:0] v, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) step(1'b0, v[i]);
  endtask

  task automatic send_byte(input logic [7:0] v);
    send_bits(v, 8);
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b1, 1'b0);
  endtask

  task automatic check_out(input string tag, input logic [7:0] d, input logic v, input logic a);
    check({tag, ".data"},   data_out,        d);
    check({tag, ".valid"},  {7'd0, valid_out}, {7'd0, v});
    check({tag, ".active"}, {7'd0, active},    {7'd0, a});
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk_32f) begin
    if (cmp_en) begin
      check("cyc.data",   data_out,          exp_data);
      check("cyc.valid",  {7'd0, valid_out}, {7'd0, exp_valid});
      check("cyc.active", {7'd0, active},    {7'd0, exp_active});
    end
  end

  initial begin
    n_vec   = 0;
    n_miss  = 0;
    cmp_en  = 1'b0;
    reset   = 1'b1;
    data_in = 1'b0;
    model_edge(1'b1, 1'b0);

    // Reset held three cycles.
    do_reset(3);
    check_out("rst", 8'h00, 1'b0, 1'b0);

    // Four idle bytes: active rises exactly on edge 32, never on 31.
    for (int i = 0; i < 3; i++) send_byte(IDLE);
    check_out("sync3", 8'h00, 1'b0, 1'b0);
    send_bits(IDLE, 7);
    check_out("edge31", 8'h00, 1'b0, 1'b0);
    step(1'b0, IDLE[0]);
    check_out("edge32", 8'h00, 1'b0, 1'b1);

    // Data stream with an embedded idle byte.
    send_byte(8'h05);
    check_out("d05", 8'h05, 1'b1, 1'b1);
    send_byte(8'h13);
    check_out("d13", 8'h13, 1'b1, 1'b1);
    send_byte(IDLE);
    check_out("dBC", 8'h13, 1'b0, 1'b1);
    send_byte(8'h9F);
    check_out("d9F", 8'h9F, 1'b1, 1'b1);

    // Broken idle run must restart the count.
    do_reset(2);
    check_out("rst2", 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(IDLE);
    send_byte(8'h2E);
    check_out("brk2E", 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(IDLE);
    check_out("brk3", 8'h00, 1'b0, 1'b0);
    send_byte(IDLE);
    check_out("brk4", 8'h00, 1'b0, 1'b1);

    // Reset in the middle of a data byte while active.
    send_byte(8'hA5);
    check_out("dA5", 8'hA5, 1'b1, 1'b1);
    send_bits(8'h3C, 4);
    do_reset(1);
    check_out("midrst", 8'h00, 1'b0, 1'b0);
    send_byte(8'h77);
    check_out("search77", 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(IDLE);
    check_out("resync3", 8'h00, 1'b0, 1'b0);
    send_byte(IDLE);
    check_out("resync4", 8'h00, 1'b0, 1'b1);
    send_byte(8'h00);
    check_out("d00", 8'h00, 1'b1, 1'b1);
    send_byte(8'hFF);
    check_out("dFF", 8'hFF, 1'b1, 1'b1);
    send_byte(IDLE);
    check_out("tailBC", 8'hFF, 1'b0, 1'b1);

    @(negedge clk_32f);
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
